hex_scan_controller: RTL and testbench

HEX_SCAN_CONTROLLER -- requirements
Module: hex_scan_controller

---
 rtl/hex_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_hex_scan_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// Multiplexed seven-segment scan controller with a double-buffered display value.
// New values are committed only at frame boundaries, so no frame mixes old and new data.
module hex_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_in_i,
  input  logic                    blank_lz_i,
  output logic                    ready_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic [6:0]              hex_o,
  output logic                    frame_done_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {OFF, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    pend_off_q, pend_off_d;
  logic                    frame_q, frame_d;
  logic                    wrap;
  logic                    accept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= OFF;
      div_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      pend_off_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_off_q <= pend_off_d;
      frame_q    <= frame_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_off_d = pend_off_q;
    wrap       = 1'b0;
    accept     = load_i && !pending_q;

    case (state_q)
      OFF: begin
        div_d = '0;
        idx_d = '0;
        if (en_i) state_d = SCAN;
      end
      default: begin
        if (!en_i) begin
          state_d = OFF;
          div_d   = '0;
          idx_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    frame_d = wrap;

    // A value accepted while the display was off is committed on the very next edge,
    // even if scanning started on the acceptance edge.
    if (pending_q && (state_q == OFF || pend_off_q || wrap)) begin
      disp_d     = shadow_q;
      pending_d  = 1'b0;
      pend_off_d = 1'b0;
    end

    if (accept) begin
      shadow_d   = data_in_i;
      pending_d  = 1'b1;
      pend_off_d = (state_q == OFF);
    end
  end

  // lz[i]: nibbles i..NUM_DIGITS-1 of the display value are all zero.
  logic [NUM_DIGITS-1:0] lz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lz[gi] = (disp_q[4*gi +: 4] == 4'h0);
      end else begin : g_lower
        assign lz[gi] = (disp_q[4*gi +: 4] == 4'h0) && lz[gi+1];
      end
      assign digit_sel_o[gi] = !((state_q == SCAN) && (idx_q == IDX_W'(gi)));
    end
  endgenerate

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;
      4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  logic [3:0] cur_nib;
  logic       cur_blank;

  always_comb begin
    cur_nib   = disp_q[4*int'(idx_q) +: 4];
    cur_blank = blank_lz_i && (idx_q != '0) && lz[idx_q];
    if (state_q != SCAN || cur_blank) hex_o = 7'b1111111;
    else                              hex_o = seg_of(cur_nib);
  end

  assign ready_o      = !pending_q;
  assign frame_done_o = frame_q;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Scoreboard bench for hex_scan_controller: a cycle-level reference model predicts every
// output cycle, a separate monitor compares the DUT against the queued predictions.
module tb_hex_scan_controller;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic          blank_lz = 1'b0;
  logic          ready;
  logic [N-1:0]  digit_sel;
  logic [6:0]    hex;
  logic          frame_done;

  hex_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(D)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_in_i(data_in),
    .blank_lz_i(blank_lz), .ready_o(ready), .digit_sel_o(digit_sel), .hex_o(hex),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   hex;
    logic [N-1:0] sel;
    logic         rdy;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: scanning position is just "cycles spent scanning" t.
  bit          m_scan;
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend, m_pend_off;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic void model_reset();
    m_scan = 0; m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_pend_off = 0;
  endfunction

  function automatic exp_t model_out(input bit b);
    exp_t e;
    int   d;
    logic [15:0] upper;
    e.rdy = !m_pend;
    if (!m_scan) begin
      e.hex = 7'h7F; e.sel = '1; e.fd = 1'b0;
    end else begin
      d      = (m_t / D) % N;
      upper  = m_disp >> (4 * d);
      e.sel  = '1;
      e.sel[d] = 1'b0;
      e.fd   = (m_t != 0) && (m_t % (D * N) == 0);
      e.hex  = (b && d > 0 && upper == 16'h0) ? 7'h7F : seg(upper[3:0]);
    end
    return e;
  endfunction

  function automatic void model_step(input bit e, input bit l, input logic [15:0] v);
    bit wrap;
    wrap = m_scan && e && ((m_t + 1) % (D * N) == 0);
    if (m_pend && (!m_scan || m_pend_off || wrap)) begin
      m_disp = m_shadow; m_pend = 0; m_pend_off = 0;
    end else if (l && !m_pend) begin
      m_shadow = v; m_pend = 1; m_pend_off = !m_scan;
    end
    if (m_scan && e)       m_t = m_t + 1;
    else if (m_scan && !e) begin m_scan = 0; m_t = 0; end
    else if (e)            begin m_scan = 1; m_t = 0; end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit l, input logic [15:0] v, input bit b);
    @(posedge clk);
    #1;
    rst = r; en = e; load = l; data_in = v; blank_lz = b;
    cycle++;
    if (r) model_reset();
    exp_q.push_back(model_out(b));
    if (!r) begin
      if (l && !m_pend)
        $display("cycle %0d: load 0x%h accepted (scan=%0d)", cycle, v, m_scan);
      model_step(e, l, v);
    end
  endtask

  task automatic run(input int n, input bit e, input bit b);
    for (int i = 0; i < n; i++) cyc(1'b0, e, 1'b0, 16'h0, b);
  endtask

  // Monitor: the DUT presents a display output every cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      checks++;
      if (hex !== e.hex || digit_sel !== e.sel || ready !== e.rdy || frame_done !== e.fd) begin
        errors++;
        $display("FAIL outputs cycle %0d: got hex=%b sel=%b rdy=%b fd=%b, expected hex=%b sel=%b rdy=%b fd=%b",
                 cycle, hex, digit_sel, ready, frame_done, e.hex, e.sel, e.rdy, e.fd);
      end
    end
  end

  initial begin : driver
    bit r_en, r_blz;
    int budget;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    // Load while off, then scan two frames.
    cyc(1'b0, 1'b0, 1'b1, 16'h12AF, 1'b0);
    run(36, 1'b1, 1'b0);
    // Load 1234, then 5678 mid-frame with an ignored second request.
    cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
    run(30, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h5678, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
    run(36, 1'b1, 1'b0);
    // Leading-zero blanking.
    cyc(1'b0, 1'b1, 1'b1, 16'h0007, 1'b1);
    run(36, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
    run(36, 1'b1, 1'b1);
    run(8, 1'b1, 1'b0);
    // Drop en mid-frame, then restart.
    run(10, 1'b0, 1'b1);
    run(20, 1'b1, 1'b1);
    // Reset mid-frame with a load pending.
    cyc(1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0);
    run(3, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    run(36, 1'b1, 1'b0);
    // Randomized traffic.
    r_en = 1; r_blz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) r_en  = !r_en;
      if ($urandom_range(29) == 0) r_blz = !r_blz;
      cyc(($urandom_range(399) == 0), r_en, ($urandom_range(7) == 0),
          16'($urandom_range(3) == 0 ? $urandom_range(255) : $urandom_range(65535)), r_blz);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
